// File: rtl/adder_bist_pkg.sv
// Shared types and constants for the adder BIST controller and its MISR.
package adder_bist_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } bist_state_e;

    localparam int DUT_LATENCY = 2;

    localparam logic [31:0] DEF_LFSR_SEED = 32'h0001_0002;
    localparam logic [31:0] DEF_LFSR_TAPS = 32'h8020_0003;
    localparam logic [16:0] DEF_MISR_TAPS = 17'h1_2000;

endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register; shift-left with feedback parity, XOR-compacts din when en.
module bist_misr
    import adder_bist_pkg::*;
#(
    parameter int               WIDTH = 17,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEF_MISR_TAPS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] sig
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            sig <= '0;
        end else if (en) begin
            sig <= {sig[WIDTH-2:0], ^(sig & TAPS)} ^ din;
        end
    end

endmodule

// File: rtl/adder_bist_ctrl.sv
// BIST controller for the pipelined adder: LFSR operand generation, MISR compaction
// of the adder results and golden-signature comparison at end of run.
module adder_bist_ctrl
    import adder_bist_pkg::*;
#(
    parameter int                  ADD_BIT   = 16,
    parameter int                  PATTERNS  = 256,
    parameter logic [2*ADD_BIT-1:0] LFSR_SEED = DEF_LFSR_SEED,
    parameter logic [2*ADD_BIT-1:0] LFSR_TAPS = DEF_LFSR_TAPS,
    parameter logic [ADD_BIT:0]     MISR_TAPS = DEF_MISR_TAPS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [ADD_BIT:0]   golden_sig,
    output logic               dut_enable,
    output logic [ADD_BIT-1:0] dut_A,
    output logic [ADD_BIT-1:0] dut_B,
    input  logic [ADD_BIT:0]   dut_Dout,
    input  logic               dut_out_valid,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [ADD_BIT:0]   signature
);

    localparam int LW = 2 * ADD_BIT;
    localparam int SW = ADD_BIT + 1;
    localparam int CW = $clog2(PATTERNS + 1);
    localparam logic [CW-1:0] LAST = CW'(PATTERNS);

    bist_state_e           state;
    bist_state_e           state_next;
    logic [LW-1:0]         lfsr;
    logic [CW-1:0]         cnt;
    logic [DUT_LATENCY-1:0] cap;
    logic                  valid_seen;
    logic                  start_run;
    logic                  capture;
    logic [SW-1:0]         misr_peek;
    logic [SW-1:0]         misr_final;

    function automatic logic [LW-1:0] lfsr_step(input logic [LW-1:0] v);
        return {v[LW-2:0], ^(v & LFSR_TAPS)};
    endfunction

    assign start_run = start && (state == IDLE || state == DONE);
    assign capture   = cap[DUT_LATENCY-1];
    assign busy      = (state == RUN) || (state == DRAIN);
    assign done      = (state == DONE);

    // The final capture lands on the DRAIN->DONE edge, so pass must see the MISR value being written then.
    assign misr_peek  = {signature[SW-2:0], ^(signature & MISR_TAPS)} ^ dut_Dout;
    assign misr_final = capture ? misr_peek : signature;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (start) state_next = RUN;
            RUN:   if (cnt == LAST) state_next = DRAIN;
            DRAIN: if (cap[DUT_LATENCY-2:0] == '0) state_next = DONE;
            DONE:  if (start) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    // lfsr holds the pattern that follows the one currently on dut_A/dut_B.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr       <= LFSR_SEED;
            cnt        <= '0;
            cap        <= '0;
            valid_seen <= 1'b0;
            pass       <= 1'b0;
            dut_enable <= 1'b0;
            dut_A      <= '0;
            dut_B      <= '0;
        end else begin
            cap <= {cap[DUT_LATENCY-2:0], dut_enable};
            if (capture && dut_out_valid) begin
                valid_seen <= 1'b1;
            end
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        dut_enable <= 1'b1;
                        dut_A      <= LFSR_SEED[LW-1:ADD_BIT];
                        dut_B      <= LFSR_SEED[ADD_BIT-1:0];
                        lfsr       <= lfsr_step(LFSR_SEED);
                        cnt        <= CW'(1);
                        valid_seen <= 1'b0;
                        pass       <= 1'b0;
                    end
                end
                RUN: begin
                    if (cnt == LAST) begin
                        dut_enable <= 1'b0;
                    end else begin
                        dut_enable <= 1'b1;
                        dut_A      <= lfsr[LW-1:ADD_BIT];
                        dut_B      <= lfsr[ADD_BIT-1:0];
                        lfsr       <= lfsr_step(lfsr);
                        cnt        <= cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (state_next == DONE) begin
                        pass <= (misr_final == golden_sig) &&
                                (valid_seen || (capture && dut_out_valid));
                    end
                end
                default: ;
            endcase
        end
    end

    bist_misr #(
        .WIDTH (SW),
        .TAPS  (MISR_TAPS)
    ) u_misr (
        .clk   (clk),
        .reset (reset),
        .clear (start_run),
        .en    (capture),
        .din   (dut_Dout),
        .sig   (signature)
    );

endmodule

// File: tb/tb_adder_bist_ctrl.sv
// Self-checking bench for adder_bist_ctrl with behavioural 2-stage adder models.
module tb_adder_bist_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // PATTERNS=1 instance
    logic        start1;
    logic [16:0] gold1;
    logic        en1;
    logic [15:0] a1, b1;
    logic [16:0] dout1;
    logic        ov1, busy1, done1, pass1;
    logic [16:0] sig1;

    // PATTERNS=256 instance
    logic        start2;
    logic [16:0] gold2;
    logic        en2;
    logic [15:0] a2, b2;
    logic [16:0] dout2;
    logic        ov2, busy2, done2, pass2;
    logic [16:0] sig2;
    int          fault;   // 0 ideal, 1 Dout[16] stuck-at-0, 2 adder held in reset

    adder_bist_ctrl #(.PATTERNS(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .golden_sig(gold1),
        .dut_enable(en1), .dut_A(a1), .dut_B(b1), .dut_Dout(dout1),
        .dut_out_valid(ov1), .busy(busy1), .done(done1), .pass(pass1),
        .signature(sig1)
    );

    adder_bist_ctrl #(.PATTERNS(256)) u_dut2 (
        .clk(clk), .reset(reset), .start(start2), .golden_sig(gold2),
        .dut_enable(en2), .dut_A(a2), .dut_B(b2), .dut_Dout(dout2),
        .dut_out_valid(ov2), .busy(busy2), .done(done2), .pass(pass2),
        .signature(sig2)
    );

    logic [16:0] s1_1, s1_2;
    logic        v1_1, v1_2;

    always_ff @(posedge clk) begin
        if (reset) begin
            v1_1 <= 1'b0; s1_1 <= '0; dout1 <= '0; ov1 <= 1'b0;
        end else begin
            v1_1  <= en1;
            s1_1  <= {1'b0, a1} + {1'b0, b1};
            dout1 <= s1_1;
            ov1   <= ov1 | v1_1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || fault == 2) begin
            v1_2 <= 1'b0; s1_2 <= '0; dout2 <= '0; ov2 <= 1'b0;
        end else begin
            v1_2  <= en2;
            s1_2  <= {1'b0, a2} + {1'b0, b2};
            dout2 <= (fault == 1) ? {1'b0, s1_2[15:0]} : s1_2;
            ov2   <= ov2 | v1_2;
        end
    end

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
    } pair_t;
    pair_t q[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_step(input logic [31:0] v);
        return {v[30:0], ^(v & 32'h8020_0003)};
    endfunction

    function automatic logic [16:0] ref_sig(input int n, input int flt);
        logic [31:0] l;
        logic [16:0] m;
        logic [16:0] d;
        l = 32'h0001_0002;
        m = '0;
        for (int i = 0; i < n; i++) begin
            d = {1'b0, l[31:16]} + {1'b0, l[15:0]};
            if (flt == 1) d[16] = 1'b0;
            if (flt == 2) d = '0;
            m = {m[15:0], ^(m & 17'h1_2000)} ^ d;
            l = ref_step(l);
        end
        return m;
    endfunction

    task automatic push_patterns(input int n);
        logic [31:0] l;
        l = 32'h0001_0002;
        for (int i = 0; i < n; i++) begin
            q.push_back({l[31:16], l[15:0]});
            l = ref_step(l);
        end
    endtask

    task automatic pop_compare();
        pair_t p;
        if (q.size() == 0) begin
            check("extra_enable", 32'd1, 32'd0);
        end else begin
            p = q.pop_front();
            check("pattern_a", {16'h0, a2}, {16'h0, p.a});
            check("pattern_b", {16'h0, b2}, {16'h0, p.b});
        end
    endtask

    task automatic do_run(input logic [16:0] gold, input int glitch_at,
                          output logic [16:0] sig_o, output logic pass_o);
        int en_cnt, busy_cnt, k;
        gold2 = gold;
        push_patterns(256);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        en_cnt = 0; busy_cnt = 0; k = 0;
        while (!done2 && k < 600) begin
            if (en2) pop_compare();
            en_cnt += int'(en2);
            busy_cnt += int'(busy2);
            start2 = (k == glitch_at);
            @(negedge clk);
            k++;
        end
        start2 = 1'b0;
        check("run_done", {31'h0, done2}, 32'd1);
        check("enable_cycles", en_cnt, 256);
        check("busy_cycles", busy_cnt, 258);
        check("queue_empty", q.size(), 0);
        sig_o  = sig2;
        pass_o = pass2;
    endtask

    typedef struct {
        int   flt;
        logic gold_ok;
        logic exp_pass;
    } vec_t;

    vec_t vecs[4];

    initial begin
        logic [16:0] good_sig, s_a, s_b;
        logic        p_a, p_b;
        int          k;

        vecs[0] = '{0, 1'b1, 1'b1};
        vecs[1] = '{1, 1'b1, 1'b0};
        vecs[2] = '{2, 1'b1, 1'b0};
        vecs[3] = '{0, 1'b0, 1'b0};
        good_sig = ref_sig(256, 0);

        reset = 1'b1; fault = 0;
        start1 = 1'b0; start2 = 1'b0; gold1 = '0; gold2 = '0;
        repeat (3) @(negedge clk);
        check("rst_enable", {31'h0, en2}, 32'd0);
        check("rst_ab", {a2, b2}, 32'd0);
        check("rst_busy_done_pass", {29'h0, busy2, done2, pass2}, 32'd0);
        check("rst_sig", {15'h0, sig2}, 32'd0);
        check("rst_dut1", {12'h0, en1, busy1, done1, pass1, a1}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // single pattern: seed drives A/B, result 1+2 compacts to 3
        gold1 = 17'h00003;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        check("p1_c1_enable", {31'h0, en1}, 32'd1);
        check("p1_c1_ab", {a1, b1}, 32'h0001_0002);
        check("p1_c1_busy", {31'h0, busy1}, 32'd1);
        @(negedge clk);
        check("p1_c2_enable", {31'h0, en1}, 32'd0);
        check("p1_c2_hold_ab", {a1, b1}, 32'h0001_0002);
        check("p1_c2_busy", {31'h0, busy1}, 32'd1);
        @(negedge clk);
        check("p1_c3_done", {30'h0, busy1, done1}, 32'd2);
        @(negedge clk);
        check("p1_c4_done_pass", {30'h0, done1, pass1}, 32'd3);
        check("p1_c4_busy", {31'h0, busy1}, 32'd0);
        check("p1_sig", {15'h0, sig1}, 32'h0000_0003);

        for (int i = 0; i < 4; i++) begin
            fault = vecs[i].flt;
            do_run(vecs[i].gold_ok ? good_sig : (good_sig ^ 17'h1), -1, s_a, p_a);
            check("vec_sig", {15'h0, s_a}, {15'h0, ref_sig(256, vecs[i].flt)});
            check("vec_pass", {31'h0, p_a}, {31'h0, vecs[i].exp_pass});
        end
        fault = 0;

        // reset during pattern 100
        gold2 = good_sig;
        push_patterns(256);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        k = 0;
        while (k < 100 && busy2) begin
            if (en2) begin
                pop_compare();
                k++;
            end
            if (k < 100) @(negedge clk);
        end
        check("mid_reached_100", k, 100);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        check("mid_rst_busy_done", {30'h0, busy2, done2}, 32'd0);
        check("mid_rst_enable", {31'h0, en2}, 32'd0);
        check("mid_rst_sig", {15'h0, sig2}, 32'd0);
        @(negedge clk);
        do_run(good_sig, -1, s_a, p_a);
        check("after_rst_sig", {15'h0, s_a}, {15'h0, good_sig});
        check("after_rst_pass", {31'h0, p_a}, 32'd1);

        // start during RUN ignored; start from DONE reruns identically
        do_run(good_sig, 10, s_a, p_a);
        check("glitch_sig", {15'h0, s_a}, {15'h0, good_sig});
        check("glitch_pass", {31'h0, p_a}, 32'd1);
        do_run(good_sig, -1, s_b, p_b);
        check("rerun_sig", {15'h0, s_b}, {15'h0, good_sig});
        check("rerun_pass", {31'h0, p_b}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_bist_ctrl.md
Name: adder_bist_ctrl

Overview:
Built-in self-test controller for the pipelined ADDER block. It generates pseudo-random A/B operand pairs from an LFSR and drives the adder's enable/A/B inputs, one pattern per cycle. It consumes the adder's Dout/out_valid outputs and compacts every result into a MISR signature. At end of run it compares the signature against a golden value and reports pass/fail. It sits between the test-access logic and the adder instance.

Parameters:
ADD_BIT, 16, operand width; must match the adder instance.
PATTERNS, 256, number of operand pairs applied per run (1..65535).
LFSR_SEED, 32'h0001_0002, initial LFSR state (2*ADD_BIT bits, nonzero); A = upper half, B = lower half.
LFSR_TAPS, 32'h8020_0003, Fibonacci feedback mask (x^32+x^22+x^2+x+1).
MISR_TAPS, 17'h1_2000, MISR feedback mask, ADD_BIT+1 bits (x^17+x^14+1).

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; begins a run from IDLE or DONE
golden_sig  in  ADD_BIT+1  expected signature, sampled at end of run
dut_enable  out  1  to adder enable; high exactly one cycle per applied pattern
dut_A  out  ADD_BIT  to adder A
dut_B  out  ADD_BIT  to adder B
dut_Dout  in  ADD_BIT+1  from adder Dout (MSB = carry)
dut_out_valid  in  1  from adder out_valid (sticky)
busy  out  1  high in RUN and DRAIN
done  out  1  high in DONE
pass  out  1  valid while done; 1 = signature matched and valid seen
signature  out  ADD_BIT+1  current MISR value

Behaviour:
- Interface fixed: reset is reset, synchronous, active-high; clock is clk.
- Reset: state=IDLE, LFSR=LFSR_SEED, MISR=0, pattern counter=0, capture pipe=0. Outputs: dut_enable=0, dut_A=0, dut_B=0, busy=0, done=0, pass=0, signature=0.
- The adder pipeline is fixed at 2 cycles: an operand pair driven in cycle t has its Dout registered after edge t+2. The controller samples dut_Dout on that edge via a 2-stage internal capture shift register fed by dut_enable.
- dut_out_valid is sticky in the adder, so it is not a per-pattern strobe. It is used only as a liveness check: valid_seen is set if dut_out_valid=1 on any capture edge.
- FSM:
  - IDLE: on start, go to RUN. LFSR is reloaded with LFSR_SEED, and MISR, counter and valid_seen are cleared.
  - RUN: dut_enable=1; dut_A/dut_B = LFSR halves, registered outputs. The first pattern is the seed itself. LFSR advances each cycle and the counter increments. After PATTERNS cycles, go to DRAIN.
  - DRAIN: dut_enable=0 and dut_A/dut_B hold their last value. Stay 2 cycles until the capture pipe empties, then go to DONE.
  - DONE: pass = (MISR == golden_sig) && valid_seen, registered on DONE entry. On start, re-run exactly as from IDLE.
- MISR update on each capture edge: misr_next = {misr[ADD_BIT-1:0], ^(misr & MISR_TAPS)} ^ dut_Dout.
- LFSR update: lfsr_next = {lfsr[2*ADD_BIT-2:0], ^(lfsr & LFSR_TAPS)}.
- start while busy: ignored.
- Reset mid-run: immediate return to IDLE with reset values. Captures in flight are discarded.
- Reset and start in the same cycle: reset wins.
- Counter wrap is impossible; its width is clog2(PATTERNS+1).

Decomposition:
- Package adder_bist_pkg holds:
  - state enum: IDLE, RUN, DRAIN, DONE
  - DUT_LATENCY = 2
  - default tap masks
- One sub-module is natural: bist_misr, parameterised width and taps, with ports clk, reset, clear, en, din, sig. Reuse it for other BIST targets.
- The LFSR stays inline.

Test Plan:
1. PATTERNS=1, seed 32'h0001_0002, ideal adder connected -> dut_A=16'h0001, dut_B=16'h0002 for one cycle; signature=17'h00003; with golden_sig=17'h00003, done=1 and pass=1 four cycles after start.
2. PATTERNS=256, ideal adder, golden from the bench reference model -> pass=1; dut_enable high for exactly 256 cycles; busy for 258 cycles.
3. Same as 2, but Dout bit 16 stuck-at-0 -> pass=0, done=1.
4. Adder held in reset (out_valid stays 0), correct golden_sig -> pass=0 because valid_seen=0.
5. Assert reset at pattern 100 of a run -> next cycle: IDLE, busy=0, signature=0, dut_enable=0. A subsequent start reproduces the scenario-2 signature.
6. Pulse start during RUN and again in DONE -> first pulse ignored; second restarts the run and yields an identical signature and pass.
